// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
// Shared encodings for the multi-cycle MIPS-style control unit: FSM state
// codes, opcode class codes (op[5:4]), ALUOp and PCSrc selector codes and
// error cause codes, plus small opcode-subclass helpers.
package mc_ctrl_pkg;

    // State codes are visible on the debug port, so the values are fixed.
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd5
    } state_t;

    // Opcode classes, taken from op[5:4].
    localparam logic [1:0] CLASS_COMPUTE = 2'b00;
    localparam logic [1:0] CLASS_IMM_MEM = 2'b01;
    localparam logic [1:0] CLASS_XFER    = 2'b10;
    localparam logic [1:0] CLASS_ILLEGAL = 2'b11;

    // Memory subclasses within CLASS_IMM_MEM, taken from op[3:2].
    localparam logic [1:0] SUB_LOAD  = 2'b10;
    localparam logic [1:0] SUB_STORE = 2'b11;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] PCSRC_PC4    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    function automatic logic is_load(input logic [1:0] cls, input logic [1:0] sub);
        return (cls == CLASS_IMM_MEM) && (sub == SUB_LOAD);
    endfunction

    function automatic logic is_store(input logic [1:0] cls, input logic [1:0] sub);
        return (cls == CLASS_IMM_MEM) && (sub == SUB_STORE);
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_wait_timer.sv
// mc_wait_timer
// Counts consecutive cycles the controller spends waiting on memory and flags
// the cycle on which the wait would reach MEM_TIMEOUT cycles.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   waiting   - controller is in a memory-wait state with mem_ready low
//   clear     - controller changes state this cycle
//   expired   - this is the MEM_TIMEOUT-th consecutive waiting cycle
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic clear,
    output logic expired
);

    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    // count_q holds the number of wait cycles already elapsed, so the
    // MEM_TIMEOUT-th wait cycle is the one that sees count_q == LIMIT.
    localparam logic [CW-1:0] LIMIT = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;
    localparam logic ENABLED = (MEM_TIMEOUT > 0);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear || !waiting) begin
            count_d = '0;
        end else if (count_q != LIMIT) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Gated by waiting, so a mem_ready arriving on the limit cycle wins.
    assign expired = ENABLED && waiting && (count_q == LIMIT);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm
// Multi-cycle control unit: sequences each instruction through
// IF/ID/EX/MEM/WB, drives all datapath strobes and traps illegal opcodes and
// memory timeouts into a sticky ERR state that only rst leaves.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   op           - opcode from IR[31:26], valid from ID onward
//   zero         - ALU zero flag (branch decision)
//   mem_ready    - memory access complete this cycle
//   IRWr..MemToReg, PCSrc, ALUOp - datapath strobes (combinational)
//   state        - current FSM state (debug)
//   err/err_code - sticky error flag and first error cause
//   fetch_count  - completed fetches, wrapping
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int COUNT_W     = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               IRWr,
    output logic               PCWr,
    output logic [1:0]         PCSrc,
    output logic               MemRd,
    output logic               MemWr,
    output logic               ALUSrc,
    output logic [1:0]         ALUOp,
    output logic               RegWr,
    output logic               RegDst,
    output logic               MemToReg,
    output logic [2:0]         state,
    output logic               err,
    output logic [1:0]         err_code,
    output logic [COUNT_W-1:0] fetch_count
);

    state_t             state_q, state_d;
    logic [5:0]         op_q, op_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [COUNT_W-1:0] fetch_count_q, fetch_count_d;

    logic               waiting;
    logic               clear;
    logic               expired;

    logic [1:0]         op_cls;
    logic [1:0]         op_sub;
    logic               op_q_unused;

    assign op_cls = op_q[5:4];
    assign op_sub = op_q[3:2];
    // op bit 1 has no control meaning in this opcode map.
    assign op_q_unused = op_q[1];

    assign waiting = ((state_q == S_IF) || (state_q == S_MEM)) && !mem_ready;
    assign clear   = (state_d != state_q);

    mc_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .waiting (waiting),
        .clear   (clear),
        .expired (expired)
    );

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        err_code_d    = err_code_q;
        fetch_count_d = fetch_count_q;
        IRWr          = 1'b0;
        PCWr          = 1'b0;
        PCSrc         = PCSRC_PC4;
        MemRd         = 1'b0;
        MemWr         = 1'b0;
        ALUSrc        = 1'b0;
        ALUOp         = ALUOP_ADD;
        RegWr         = 1'b0;
        RegDst        = 1'b0;
        MemToReg      = 1'b0;

        case (state_q)
            S_IF: begin
                MemRd = 1'b1;
                if (mem_ready) begin
                    IRWr          = 1'b1;
                    PCWr          = 1'b1;
                    PCSrc         = PCSRC_PC4;
                    fetch_count_d = fetch_count_q + COUNT_W'(1);
                    state_d       = S_ID;
                end else if (expired) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_ERR;
                end
            end

            S_ID: begin
                // The IR was loaded on the IF->ID edge, so decode the live op
                // here and keep a copy for the later phases.
                op_d = op;
                if (op[5:4] == CLASS_ILLEGAL) begin
                    err_code_d = ERR_ILLEGAL;
                    state_d    = S_ERR;
                end else begin
                    state_d = S_EX;
                end
            end

            S_EX: begin
                case (op_cls)
                    CLASS_COMPUTE: begin
                        ALUSrc  = 1'b0;
                        ALUOp   = ALUOP_FUNC;
                        state_d = S_WB;
                    end
                    CLASS_IMM_MEM: begin
                        ALUSrc  = 1'b1;
                        ALUOp   = ALUOP_ADD;
                        state_d = op_sub[1] ? S_MEM : S_WB;
                    end
                    CLASS_XFER: begin
                        if (op_q[0]) begin
                            ALUSrc = 1'b0;
                            ALUOp  = ALUOP_SUB;
                            PCSrc  = PCSRC_BRANCH;
                            PCWr   = zero;
                        end else begin
                            PCSrc  = PCSRC_JUMP;
                            PCWr   = 1'b1;
                        end
                        state_d = S_IF;
                    end
                    default: begin
                        // Unreachable: illegal opcodes are trapped in ID.
                        err_code_d = ERR_ILLEGAL;
                        state_d    = S_ERR;
                    end
                endcase
            end

            S_MEM: begin
                MemRd = is_load(op_cls, op_sub);
                MemWr = is_store(op_cls, op_sub);
                if (mem_ready) begin
                    state_d = is_load(op_cls, op_sub) ? S_WB : S_IF;
                end else if (expired) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_ERR;
                end
            end

            S_WB: begin
                RegWr    = 1'b1;
                RegDst   = (op_cls == CLASS_COMPUTE);
                MemToReg = is_load(op_cls, op_sub);
                state_d  = S_IF;
            end

            S_ERR: begin
                state_d = S_ERR;
            end

            default: begin
                state_d = S_IF;
            end
        endcase

        // Strobes must drop in the very cycle rst rises, before the
        // asynchronous reset has any edge to act on downstream logic.
        if (rst) begin
            IRWr     = 1'b0;
            PCWr     = 1'b0;
            PCSrc    = PCSRC_PC4;
            MemRd    = 1'b0;
            MemWr    = 1'b0;
            ALUSrc   = 1'b0;
            ALUOp    = ALUOP_ADD;
            RegWr    = 1'b0;
            RegDst   = 1'b0;
            MemToReg = 1'b0;
        end
    end

    // ERR is absorbing, so the cause written on entry is the first cause.
    assign err_d = err_q || (state_d == S_ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IF;
            op_q          <= '0;
            err_q         <= 1'b0;
            err_code_q    <= ERR_NONE;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign state       = state_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

    logic        clk;
    logic        rst;
    logic [5:0]  op;
    logic        zero;
    logic        mem_ready;
    logic        IRWr, PCWr, MemRd, MemWr, ALUSrc, RegWr, RegDst, MemToReg;
    logic [1:0]  PCSrc, ALUOp;
    logic [2:0]  state;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] fetch_count;

    int pass_cnt  = 0;
    int check_cnt = 0;

    wire [11:0] strobes = {IRWr, PCWr, MemRd, MemWr, ALUSrc, RegWr,
                           RegDst, MemToReg, PCSrc, ALUOp};

    mc_ctrl_fsm #(
        .COUNT_W     (16),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .op          (op),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .IRWr        (IRWr),
        .PCWr        (PCWr),
        .PCSrc       (PCSrc),
        .MemRd       (MemRd),
        .MemWr       (MemWr),
        .ALUSrc      (ALUSrc),
        .ALUOp       (ALUOp),
        .RegWr       (RegWr),
        .RegDst      (RegDst),
        .MemToReg    (MemToReg),
        .state       (state),
        .err         (err),
        .err_code    (err_code),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves the bench at a negedge with rst just released, DUT in IF.
    task automatic do_reset();
        rst = 1'b1; op = 6'b0; zero = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; op = 6'b0; zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        #1;
        check_cnt++;
        if (state !== 3'd0 || err !== 1'b0 || err_code !== 2'b00 || fetch_count !== 16'd0) begin
            $display("FAIL reset_state: state=%0d err=%b code=%b fc=%0d, want 0/0/00/0",
                     state, err, err_code, fetch_count);
        end else pass_cnt++;
        check_cnt++;
        if (strobes !== 12'b0) $display("FAIL reset_strobes: got %b want 0", strobes);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        $display("reset: state=%0d strobes=%b", state, strobes);
    endtask

    task automatic test_compute();
        do_reset();
        op = 6'b000000; mem_ready = 1'b1;
        #1;
        check_cnt++;
        if (IRWr !== 1'b1 || PCWr !== 1'b1 || MemRd !== 1'b1 || state !== 3'd0)
            $display("FAIL compute_if: IRWr=%b PCWr=%b MemRd=%b state=%0d want 1/1/1/0", IRWr, PCWr, MemRd, state);
        else pass_cnt++;
        @(negedge clk); #1;
        check_cnt++;
        if (state !== 3'd1 || fetch_count !== 16'd1 || IRWr !== 1'b0)
            $display("FAIL compute_id: state=%0d fc=%0d IRWr=%b want 1/1/0", state, fetch_count, IRWr);
        else pass_cnt++;
        @(negedge clk); #1;
        check_cnt++;
        if (state !== 3'd2 || ALUOp !== 2'b10 || ALUSrc !== 1'b0 || RegWr !== 1'b0)
            $display("FAIL compute_ex: state=%0d ALUOp=%b ALUSrc=%b RegWr=%b want 2/10/0/0", state, ALUOp, ALUSrc, RegWr);
        else pass_cnt++;
        @(negedge clk); #1;
        check_cnt++;
        if (state !== 3'd4 || RegWr !== 1'b1 || RegDst !== 1'b1 || MemToReg !== 1'b0)
            $display("FAIL compute_wb: state=%0d RegWr=%b RegDst=%b MemToReg=%b want 4/1/1/0", state, RegWr, RegDst, MemToReg);
        else pass_cnt++;
        @(negedge clk); #1;
        check_cnt++;
        if (state !== 3'd0 || IRWr !== 1'b1)
            $display("FAIL compute_refetch: state=%0d IRWr=%b want 0/1", state, IRWr);
        else pass_cnt++;
        @(negedge clk); #1;
        check_cnt++;
        if (fetch_count !== 16'd2) $display("FAIL compute_count: fc=%0d want 2", fetch_count);
        else pass_cnt++;
        $display("compute op=000000: fetch_count=%0d", fetch_count);
    endtask

    task automatic test_load_wait();
        do_reset();
        op = 6'b011000; mem_ready = 1'b1;
        #1;
        check_cnt++;
        if (IRWr !== 1'b1) $display("FAIL load_if: IRWr=%b want 1", IRWr);
        else pass_cnt++;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk); #1;
        check_cnt++;
        if (state !== 3'd2 || ALUSrc !== 1'b1 || ALUOp !== 2'b00)
            $display("FAIL load_ex: state=%0d ALUSrc=%b ALUOp=%b want 2/1/00", state, ALUSrc, ALUOp);
        else pass_cnt++;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            check_cnt++;
            if (state !== 3'd3 || MemRd !== 1'b1 || MemWr !== 1'b0)
                $display("FAIL load_mem%0d: state=%0d MemRd=%b MemWr=%b want 3/1/0", i, state, MemRd, MemWr);
            else pass_cnt++;
            @(negedge clk);
        end
        #1;
        check_cnt++;
        if (state !== 3'd4 || RegWr !== 1'b1 || MemToReg !== 1'b1 || RegDst !== 1'b0)
            $display("FAIL load_wb: state=%0d RegWr=%b MemToReg=%b RegDst=%b want 4/1/1/0", state, RegWr, MemToReg, RegDst);
        else pass_cnt++;
        @(negedge clk); #1;
        check_cnt++;
        if (state !== 3'd0 || RegWr !== 1'b0) $display("FAIL load_done: state=%0d RegWr=%b want 0/0", state, RegWr);
        else pass_cnt++;
        $display("load op=011000 with 3 wait cycles: back to state=%0d", state);
    endtask

    task automatic test_branch(input logic zval);
        do_reset();
        op = 6'b100001; mem_ready = 1'b1; zero = zval;
        @(negedge clk);
        @(negedge clk); #1;
        check_cnt++;
        if (state !== 3'd2 || PCSrc !== 2'b01 || PCWr !== zval || ALUOp !== 2'b01 || ALUSrc !== 1'b0)
            $display("FAIL branch_ex_z%0b: state=%0d PCSrc=%b PCWr=%b ALUOp=%b ALUSrc=%b want 2/01/%b/01/0",
                     zval, state, PCSrc, PCWr, ALUOp, ALUSrc, zval);
        else pass_cnt++;
        @(negedge clk); #1;
        check_cnt++;
        if (state !== 3'd0) $display("FAIL branch_ret_z%0b: state=%0d want 0", zval, state);
        else pass_cnt++;
        $display("branch op=100001 zero=%b: back to IF", zval);
    endtask

    task automatic test_illegal();
        do_reset();
        op = 6'b110000; mem_ready = 1'b1;
        @(negedge clk); #1;
        check_cnt++;
        if (state !== 3'd1) $display("FAIL illegal_id: state=%0d want 1", state);
        else pass_cnt++;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            mem_ready = i[0];
            #1;
            check_cnt++;
            if (state !== 3'd5 || err !== 1'b1 || err_code !== 2'b01 || strobes !== 12'b0)
                $display("FAIL illegal_err%0d: state=%0d err=%b code=%b strobes=%b want 5/1/01/0",
                         i, state, err, err_code, strobes);
            else pass_cnt++;
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check_cnt++;
        if (state !== 3'd0 || err !== 1'b0 || err_code !== 2'b00)
            $display("FAIL illegal_clear: state=%0d err=%b code=%b want 0/0/00", state, err, err_code);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        $display("illegal op=110000: trapped and cleared by rst");
    endtask

    task automatic test_timeout();
        do_reset();
        op = 6'b000000; mem_ready = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            #1;
            check_cnt++;
            if (state !== 3'd0 || IRWr !== 1'b0 || MemRd !== 1'b1)
                $display("FAIL timeout_wait%0d: state=%0d IRWr=%b MemRd=%b want 0/0/1", i, state, IRWr, MemRd);
            else pass_cnt++;
            @(negedge clk);
        end
        #1;
        check_cnt++;
        if (state !== 3'd5 || err !== 1'b1 || err_code !== 2'b10)
            $display("FAIL timeout_err: state=%0d err=%b code=%b want 5/1/10", state, err, err_code);
        else pass_cnt++;
        $display("timeout: 15 wait cycles in IF -> state=%0d code=%b", state, err_code);
    endtask

    task automatic test_ready_at_limit();
        do_reset();
        op = 6'b000000; mem_ready = 1'b0;
        for (int i = 1; i <= 14; i++) @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check_cnt++;
        if (state !== 3'd0 || IRWr !== 1'b1)
            $display("FAIL limit_fetch: state=%0d IRWr=%b want 0/1", state, IRWr);
        else pass_cnt++;
        @(negedge clk); #1;
        check_cnt++;
        if (state !== 3'd1 || err !== 1'b0 || fetch_count !== 16'd1)
            $display("FAIL limit_id: state=%0d err=%b fc=%0d want 1/0/1", state, err, fetch_count);
        else pass_cnt++;
        $display("ready on wait cycle 15: fetched, state=%0d", state);
    endtask

    task automatic test_reset_mid_store();
        do_reset();
        op = 6'b011100; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check_cnt++;
        if (state !== 3'd3 || MemWr !== 1'b1 || MemRd !== 1'b0)
            $display("FAIL store_mem: state=%0d MemWr=%b MemRd=%b want 3/1/0", state, MemWr, MemRd);
        else pass_cnt++;
        #1;
        rst = 1'b1;
        #1;
        check_cnt++;
        if (MemWr !== 1'b0 || RegWr !== 1'b0 || state !== 3'd0)
            $display("FAIL store_abort: MemWr=%b RegWr=%b state=%0d want 0/0/0", MemWr, RegWr, state);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_cnt++;
        if (state !== 3'd0 || fetch_count !== 16'd0)
            $display("FAIL store_release: state=%0d fc=%0d want 0/0", state, fetch_count);
        else pass_cnt++;
        $display("store op=011100 aborted by rst in MEM");
    endtask

    initial begin
        rst = 1'b1; op = 6'b0; zero = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_compute();
        test_load_wait();
        test_branch(1'b1);
        test_branch(1'b0);
        test_illegal();
        test_timeout();
        test_ready_at_limit();
        test_reset_mid_store();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
